instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the processor core. It fetches an instruction word over a request/acknowledge port and latches it. It then decodes the opcode and function field into an ALU operation and drives the ALU-enable and register-file-write strobes in fixed phases. It sits between instruction memory and the ALU/register-file datapath and owns the program counter.

---
 rtl/proc_pkg.sv | 38 +++
 rtl/alu_op_decode.sv | 30 +++
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_instr_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : proc_pkg                                                    |
// | Shared opcode/funct/ALU-op constants and the sequencer state enum.    |
// | Config  : ILLEGAL_TRAP_EN adds the TRAP state.                        |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package proc_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_AR    = 6'b000010;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_NOT = 4'b0100;
  localparam logic [3:0] FN_XOR = 4'b0101;
  localparam logic [3:0] FN_SLA = 4'b0110;
  localparam logic [3:0] FN_SRA = 4'b0111;
  localparam logic [3:0] FN_SRL = 4'b1000;

  localparam logic [3:0] ALUOP_AR = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4
`ifdef ILLEGAL_TRAP_EN
    ,
    ST_TRAP      = 3'd5
`endif
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_op_decode                                               |
// | Pure combinational opcode/funct decode to ALU op plus legal flag.     |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module alu_op_decode
  import proc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [3:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  // R-type passes funct straight through for the nine defined ops; AR maps to a fixed op
  always_comb begin
    alu_op = 4'b0000;
    legal  = 1'b0;
    if ((opcode == OPC_RTYPE) && (funct <= FN_SRL)) begin
      alu_op = funct;
      legal  = 1'b1;
    end else if (opcode == OPC_AR) begin
      alu_op = ALUOP_AR;
      legal  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : instr_sequencer                                             |
// | Multi-cycle fetch/decode/execute/writeback sequencer owning the PC.   |
// | Config  : ILLEGAL_TRAP_EN - illegal instructions trap instead of NOP. |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [3:0]      alu_op,
  output logic            alu_en,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [4:0]      rf_raddr_a,
  output logic [4:0]      rf_raddr_b,
  output logic [15:0]     retired
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            trap
`endif
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [15:0]       retired_q, retired_d;
  logic [3:0]        dec_alu_op;
  logic              dec_legal;
  logic              unused_ir_bits;
`ifdef ILLEGAL_TRAP_EN
  logic              trap_q, trap_d;
`endif

  alu_op_decode u_dec (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[3:0]),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // IR[10:4] carries no meaning in this format
  assign unused_ir_bits = ^ir_q[10:4];

  // Next-state and Moore strobe generation; strobes depend only on state_q
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = alu_op_q;
    retired_d = retired_q;
`ifdef ILLEGAL_TRAP_EN
    trap_d    = trap_q;
`endif
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_op_d = dec_alu_op;
        if (dec_legal) begin
          state_d = ST_EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          trap_d  = 1'b1;
          state_d = ST_TRAP;
`else
          // Illegal word retires as a silent NOP: skip it without counting
          pc_d    = pc_q + PC_ONE;
          state_d = ST_FETCH;
`endif
        end
      end
      ST_EXECUTE: begin
        alu_en  = 1'b1;
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        rf_we     = 1'b1;
        pc_d      = pc_q + PC_ONE;
        retired_d = retired_q + 16'd1;
        state_d   = ST_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset forces IDLE so strobes fall at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= PC_RST;
      ir_q      <= 32'd0;
      alu_op_q  <= 4'd0;
      retired_q <= 16'd0;
`ifdef ILLEGAL_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      retired_q <= retired_d;
`ifdef ILLEGAL_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  assign imem_addr  = pc_q;
  assign alu_op     = alu_op_q;
  assign retired    = retired_q;
  assign rf_waddr   = ir_q[25:21];
  assign rf_raddr_a = ir_q[20:16];
  assign rf_raddr_b = ir_q[15:11];
`ifdef ILLEGAL_TRAP_EN
  assign trap       = trap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_instr_sequencer                                          |
// | Directed, table-driven bench for instr_sequencer (both configs).      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req, alu_en, rf_we;
  logic [15:0] imem_addr, retired;
  logic [3:0]  alu_op;
  logic [4:0]  rf_waddr, rf_raddr_a, rf_raddr_b;

  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = 32'd0;
  logic        req2, alu_en2, rf_we2;
  logic [3:0]  addr2, alu_op2;
  logic [4:0]  waddr2, ra2, rb2;
  logic [15:0] retired2;
`ifdef ILLEGAL_TRAP_EN
  logic        trap, trap2;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .alu_op(alu_op),
    .alu_en(alu_en), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .retired(retired)
`ifdef ILLEGAL_TRAP_EN
    , .trap(trap)
`endif
  );

  instr_sequencer #(.PC_W(4), .RESET_PC(15)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .alu_op(alu_op2),
    .alu_en(alu_en2), .rf_we(rf_we2), .rf_waddr(waddr2),
    .rf_raddr_a(ra2), .rf_raddr_b(rb2), .retired(retired2)
`ifdef ILLEGAL_TRAP_EN
    , .trap(trap2)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic        legal;
    logic [3:0]  exp_op;
    logic [4:0]  exp_rd;
    logic [4:0]  exp_rs;
    logic [4:0]  exp_rt;
  } vec_t;

  vec_t vecs[7];
  logic [15:0] exp_pc;
  logic [15:0] exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, pass through IDLE and land in the first FETCH
  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    ack2     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("idle_no_req", {31'd0, imem_req}, 32'd0);
    step();
    exp_pc  = 16'd0;
    exp_ret = 16'd0;
  endtask

  // Runs one instruction from a FETCH cycle through to the next FETCH (or TRAP)
  task automatic run_vec(input vec_t v);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
    for (int d = 0; d < v.delay; d++) begin
      imem_ack = 1'b0;
      step();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
    end
    imem_ack   = 1'b1;
    imem_rdata = v.instr;
    step();
    // DECODE: drive a noise word with ack high, which must be ignored
    imem_ack   = v.legal;
    imem_rdata = 32'hFFFF_FFFF;
    chk("dec_req", {31'd0, imem_req}, 32'd0);
    chk("dec_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, v.exp_rd});
    chk("rf_raddr_a", {27'd0, rf_raddr_a}, {27'd0, v.exp_rs});
    chk("rf_raddr_b", {27'd0, rf_raddr_b}, {27'd0, v.exp_rt});
    if (v.legal) begin
      step();
      chk("ex_alu_en", {31'd0, alu_en}, 32'd1);
      chk("ex_rf_we", {31'd0, rf_we}, 32'd0);
      chk("ex_alu_op", {28'd0, alu_op}, {28'd0, v.exp_op});
      imem_ack = 1'b0;
      step();
      chk("wb_rf_we", {31'd0, rf_we}, 32'd1);
      chk("wb_alu_en", {31'd0, alu_en}, 32'd0);
      chk("wb_alu_op", {28'd0, alu_op}, {28'd0, v.exp_op});
      chk("wb_rf_waddr", {27'd0, rf_waddr}, {27'd0, v.exp_rd});
      step();
      exp_pc  = exp_pc + 16'd1;
      exp_ret = exp_ret + 16'd1;
      chk("retired", {16'd0, retired}, {16'd0, exp_ret});
    end else begin
`ifdef ILLEGAL_TRAP_EN
      step();
      chk("trap_flag", {31'd0, trap}, 32'd1);
      for (int c = 0; c < 20; c++) begin
        imem_ack = c[0];
        step();
        if (imem_req || alu_en || rf_we || imem_addr != exp_pc || retired != exp_ret) begin
          chk("trap_hold", {imem_req, alu_en, rf_we, 13'd0, imem_addr}, {16'd0, exp_pc});
        end
      end
      chk("trap_still", {31'd0, trap}, 32'd1);
      chk("trap_ret", {16'd0, retired}, {16'd0, exp_ret});
      do_reset();
      chk("trap_cleared", {31'd0, trap}, 32'd0);
`else
      step();
      exp_pc = exp_pc + 16'd1;
      chk("nop_no_alu_en", {31'd0, alu_en}, 32'd0);
      chk("nop_retired", {16'd0, retired}, {16'd0, exp_ret});
`endif
    end
  endtask

  initial begin
    // instr, delay, legal, op, rd, rs, rt
    vecs[0] = '{32'h0022_1800, 0, 1'b1, 4'h0, 5'd1,  5'd2, 5'd3};
    vecs[1] = '{32'h0800_0000, 3, 1'b1, 4'hF, 5'd0,  5'd0, 5'd0};
    vecs[2] = '{32'h0043_2001, 1, 1'b1, 4'h1, 5'd2,  5'd3, 5'd4};
    vecs[3] = '{32'hFC22_1800, 0, 1'b0, 4'h0, 5'd1,  5'd2, 5'd3};
    vecs[4] = '{32'h03E0_F808, 0, 1'b1, 4'h8, 5'd31, 5'd0, 5'd31};
    vecs[5] = '{32'h0022_1809, 2, 1'b0, 4'h0, 5'd1,  5'd2, 5'd3};
    vecs[6] = '{32'h0000_0005, 2, 1'b1, 4'h5, 5'd0,  5'd0, 5'd0};

    // Reset values while rst_n is held low
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_ir", {17'd0, rf_waddr, rf_raddr_a, rf_raddr_b}, 32'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("rst_trap", {31'd0, trap}, 32'd0);
`endif
    do_reset();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset asserted during EXECUTE: strobes fall without waiting for a clock
    imem_ack   = 1'b1;
    imem_rdata = 32'h0022_1800;
    step();
    imem_ack = 1'b0;
    step();
    chk("pre_rst_alu_en", {31'd0, alu_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_alu_en", {31'd0, alu_en}, 32'd0);
    chk("async_req", {31'd0, imem_req}, 32'd0);
    do_reset();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", {16'd0, imem_addr}, 32'd0);
    chk("post_rst_retired", {16'd0, retired}, 32'd0);

    // Narrow PC: RESET_PC=15 wraps to 0 after one retired instruction
    chk("w4_first_addr", {28'd0, addr2}, 32'd15);
    chk("w4_first_req", {31'd0, req2}, 32'd1);
    ack2   = 1'b1;
    rdata2 = 32'h0022_1800;
    step();
    ack2 = 1'b0;
    step();
    step();
    step();
    chk("w4_wrap_req", {31'd0, req2}, 32'd1);
    chk("w4_wrap_addr", {28'd0, addr2}, 32'd0);
    chk("w4_retired", {16'd0, retired2}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
